fsmm_decoder: RTL and testbench



---
 rtl/fsmm_decoder.sv | 143 ++++++++++++++
 tb/tb_fsmm_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsmm_decoder.sv
// Decoder for the fsmm Mealy code: tracks the set of encoder states consistent with the received symbols.
// Optional statistics counters (amb_cnt, err_cnt) are enabled with `define FSMM_DEC_STATS_EN.
module fsmm_decoder #(
  parameter int NST   = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_vld,
  input  logic             m,
  input  logic             n,
  input  logic             sync,
  output logic             a_dec,
  output logic             b_dec,
  output logic             a_known,
  output logic             b_known,
  output logic             dec_vld,
  output logic [NST-1:0]   cand,
  output logic             locked,
  output logic             err
`ifdef FSMM_DEC_STATS_EN
  ,
  output logic [CNT_W-1:0] amb_cnt,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  logic [NST-1:0] r_cand;
  logic           r_err, r_dec_vld, r_a_dec, r_b_dec, r_a_known, r_b_known;

  logic w_s0, w_s1, w_s2, w_s3, w_s4;
  logic w_is00, w_is01, w_is10, w_is11;
  logic w_h00, w_h01, w_h02, w_h1, w_h20, w_h21;
  logic w_h30, w_h31, w_h32, w_h33, w_h40, w_h41;
  logic w_a0, w_a1, w_ax, w_b0, w_b1, w_bx;
  logic w_a_known, w_b_known, w_dec, w_fail;
  logic [NST-1:0] w_nxt;

  // cand is ordered {S0,S1,S2,S3,S4}, MSB = S0
  assign {w_s0, w_s1, w_s2, w_s3, w_s4} = r_cand;

  assign w_is00 = ~m & ~n;
  assign w_is01 = ~m &  n;
  assign w_is10 =  m & ~n;
  assign w_is11 =  m &  n;

  // One hit per code-table row: candidate state present and symbol matches
  assign w_h00 = w_s0 & w_is00;
  assign w_h01 = w_s0 & w_is10;
  assign w_h02 = w_s0 & w_is01;
  assign w_h1  = w_s1 & w_is11;
  assign w_h20 = w_s2 & w_is01;
  assign w_h21 = w_s2 & w_is10;
  assign w_h30 = w_s3 & w_is11;
  assign w_h31 = w_s3 & w_is11;
  assign w_h32 = w_s3 & w_is00;
  assign w_h33 = w_s3 & w_is00;
  assign w_h40 = w_s4 & w_is01;
  assign w_h41 = w_s4 & w_is11;

  assign w_nxt = {w_h00 | w_h31,
                  w_h02 | w_h41,
                  w_h1,
                  w_h21 | w_h30 | w_h33,
                  w_h01 | w_h20 | w_h32 | w_h40};

  // A bit is known only when every hit fixes it and they agree
  assign w_a0 = w_h00 | w_h20 | w_h30 | w_h33;
  assign w_a1 = w_h01 | w_h02 | w_h21 | w_h31 | w_h32;
  assign w_ax = w_h1  | w_h40 | w_h41;
  assign w_b0 = w_h02 | w_h31 | w_h33 | w_h40;
  assign w_b1 = w_h01 | w_h30 | w_h32 | w_h41;
  assign w_bx = w_h00 | w_h1  | w_h20 | w_h21;

  assign w_a_known = (w_a0 ^ w_a1) & ~w_ax;
  assign w_b_known = (w_b0 ^ w_b1) & ~w_bx;

  assign w_dec  = sym_vld & ~r_err & ~sync & ~rst;
  assign w_fail = w_dec & (w_nxt == '0);

  always_ff @(posedge clk) begin
    if (rst || sync) begin
      r_cand    <= NST'(1) << (NST - 1);
      r_err     <= 1'b0;
      r_dec_vld <= 1'b0;
      r_a_dec   <= 1'b0;
      r_b_dec   <= 1'b0;
      r_a_known <= 1'b0;
      r_b_known <= 1'b0;
    end else if (sym_vld && !r_err) begin
      r_dec_vld <= 1'b1;
      if (w_nxt == '0) begin
        r_err     <= 1'b1;
        r_cand    <= '0;
        r_a_dec   <= 1'b0;
        r_b_dec   <= 1'b0;
        r_a_known <= 1'b0;
        r_b_known <= 1'b0;
      end else begin
        r_cand    <= w_nxt;
        r_a_known <= w_a_known;
        r_b_known <= w_b_known;
        r_a_dec   <= w_a_known & w_a1;
        r_b_dec   <= w_b_known & w_b1;
      end
    end else begin
      r_dec_vld <= 1'b0;
    end
  end

  assign cand    = r_cand;
  assign err     = r_err;
  assign dec_vld = r_dec_vld;
  assign a_dec   = r_a_dec;
  assign b_dec   = r_b_dec;
  assign a_known = r_a_known;
  assign b_known = r_b_known;
  assign locked  = (r_cand != '0) && ((r_cand & (r_cand - NST'(1))) == '0);

`ifdef FSMM_DEC_STATS_EN
  logic [CNT_W-1:0] r_amb_cnt, r_err_cnt;

  // Error symbols are not decodes, so they do not count as ambiguous
  always_ff @(posedge clk) begin
    if (rst) begin
      r_amb_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_dec && !w_fail && !(w_a_known && w_b_known) && (r_amb_cnt != '1))
        r_amb_cnt <= r_amb_cnt + CNT_W'(1);
      if (w_fail && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign amb_cnt = r_amb_cnt;
  assign err_cnt = r_err_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_fsmm_decoder.sv
// Bench for fsmm_decoder: directed test-plan scenarios plus a random stream against a table-driven model.
module tb_fsmm_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0, sym_vld = 1'b0, m = 1'b0, n = 1'b0, sync = 1'b0;
  logic a_dec, b_dec, a_known, b_known, dec_vld, locked, err;
  logic [4:0] cand;
`ifdef FSMM_DEC_STATS_EN
  logic [7:0] amb_cnt, err_cnt;
`endif

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  fsmm_decoder dut (
    .clk(clk), .rst(rst), .sym_vld(sym_vld), .m(m), .n(n), .sync(sync),
    .a_dec(a_dec), .b_dec(b_dec), .a_known(a_known), .b_known(b_known),
    .dec_vld(dec_vld), .cand(cand), .locked(locked), .err(err)
`ifdef FSMM_DEC_STATS_EN
    , .amb_cnt(amb_cnt), .err_cnt(err_cnt)
`endif
  );

  // Code table rows: state, a, b (2 = don't care), symbol {m,n}, next state
  int t_st [12] = '{0, 0, 0, 1, 2, 2, 3, 3, 3, 3, 4, 4};
  int t_a  [12] = '{0, 1, 1, 2, 0, 1, 0, 1, 1, 0, 2, 2};
  int t_b  [12] = '{2, 1, 0, 2, 2, 2, 1, 0, 1, 0, 0, 1};
  int t_sym[12] = '{0, 2, 1, 3, 1, 2, 3, 3, 0, 0, 1, 3};
  int t_nx [12] = '{0, 4, 1, 2, 4, 3, 3, 0, 4, 3, 4, 1};

  // Model state: the set of possible states (index = state number)
  bit e_set[5];
  bit e_err, e_dv, e_ak, e_ad, e_bk, e_bd;

  function automatic logic [4:0] set_to_vec();
    logic [4:0] v = '0;
    for (int s = 0; s < 5; s++) if (e_set[s]) v[4-s] = 1'b1;
    return v;
  endfunction

  function automatic logic [11:0] expected();
    logic [4:0] v = set_to_vec();
    return {v, $countones(v) == 1, e_err, e_dv, e_ak, e_ad, e_bk, e_bd};
  endfunction

  function automatic logic [11:0] observed();
    return {cand, locked, err, dec_vld, a_known, a_dec, b_known, b_dec};
  endfunction

  task automatic mdl_reset();
    for (int s = 0; s < 5; s++) e_set[s] = (s == 0);
    {e_err, e_dv, e_ak, e_ad, e_bk, e_bd} = '0;
  endtask

  task automatic mdl_step(input bit r, input bit s, input bit v, input int sy);
    bit nx[5];
    bit aseen[3];
    bit bseen[3];
    bit any;
    if (r || s) begin
      mdl_reset();
      return;
    end
    if (!v || e_err) begin
      e_dv = 0;
      return;
    end
    any = 0;
    for (int i = 0; i < 5; i++) nx[i] = 0;
    for (int i = 0; i < 3; i++) begin aseen[i] = 0; bseen[i] = 0; end
    for (int i = 0; i < 12; i++)
      if (e_set[t_st[i]] && t_sym[i] == sy) begin
        nx[t_nx[i]] = 1;
        aseen[t_a[i]] = 1;
        bseen[t_b[i]] = 1;
        any = 1;
      end
    e_dv = 1;
    if (!any) begin
      e_err = 1;
      for (int i = 0; i < 5; i++) e_set[i] = 0;
      {e_ak, e_ad, e_bk, e_bd} = '0;
    end else begin
      e_set = nx;
      e_ak = !aseen[2] && (aseen[0] != aseen[1]);
      e_bk = !bseen[2] && (bseen[0] != bseen[1]);
      e_ad = e_ak && aseen[1];
      e_bd = e_bk && bseen[1];
    end
  endtask

  // One clock: inputs applied after the falling edge, outputs settle #1 after the rising edge
  task automatic cyc(input bit r, input bit s, input bit v, input logic [1:0] sy);
    @(negedge clk);
    rst = r; sync = s; sym_vld = v; {m, n} = sy;
    mdl_step(r, s, v, int'(sy));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 2'b00);
    asserts++;
    if (observed() !== 12'b10000_1_0_0_0000) begin
      fails++;
      $display("FAIL reset: got %b want %b", observed(), 12'b10000_1_0_0_0000);
    end
  endtask

  task automatic test_sequence1();
    logic [1:0]  sy [5] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
    logic [11:0] ex [5] = '{12'b01000_1_0_1_1110, 12'b00100_1_0_1_0000,
                            12'b00010_1_0_1_1100, 12'b10010_0_0_1_0000,
                            12'b01000_1_0_1_1110};
    cyc(1, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, sy[i]);
      asserts++;
      if (observed() !== ex[i]) begin
        fails++;
        $display("FAIL seq1[%0d]: got %b want %b", i, observed(), ex[i]);
      end
    end
  endtask

  task automatic test_sequence2();
    logic [1:0]  sy [3] = '{2'b10, 2'b01, 2'b11};
    logic [11:0] ex [3] = '{12'b00001_1_0_1_1111, 12'b00001_1_0_1_0010,
                            12'b01000_1_0_1_0011};
    cyc(1, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, sy[i]);
      asserts++;
      if (observed() !== ex[i]) begin
        fails++;
        $display("FAIL seq2[%0d]: got %b want %b", i, observed(), ex[i]);
      end
    end
  endtask

  task automatic test_error();
    logic [11:0] ex [3] = '{12'b00000_0_1_1_0000, 12'b00000_0_1_0_0000,
                            12'b10000_1_0_0_0000};
    cyc(1, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      cyc(0, 0, 1, 2'b11);
      else if (i == 1) cyc(0, 0, 1, 2'b00);
      else             cyc(0, 1, 1, 2'b01);
      asserts++;
      if (observed() !== ex[i]) begin
        fails++;
        $display("FAIL error[%0d]: got %b want %b", i, observed(), ex[i]);
      end
    end
  endtask

  task automatic test_hold();
    cyc(1, 0, 0, 2'b00);
    cyc(0, 0, 1, 2'b10);
    cyc(0, 0, 1, 2'b01);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 2'(i + 1));
      asserts++;
      if (observed() !== 12'b00001_1_0_0_0010) begin
        fails++;
        $display("FAIL hold[%0d]: got %b want %b", i, observed(), 12'b00001_1_0_0_0010);
      end
    end
  endtask

  task automatic test_rst_priority();
    cyc(1, 0, 0, 2'b00);
    cyc(0, 0, 1, 2'b10);
    cyc(1, 0, 1, 2'b01);
    asserts++;
    if (observed() !== 12'b10000_1_0_0_0000) begin
      fails++;
      $display("FAIL rst_prio: got %b want %b", observed(), 12'b10000_1_0_0_0000);
    end
  endtask

  task automatic test_random();
    cyc(1, 0, 0, 2'b00);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
      asserts++;
      if (observed() !== expected()) begin
        fails++;
        $display("FAIL random[%0d]: got %b want %b", i, observed(), expected());
      end
    end
  endtask

`ifdef FSMM_DEC_STATS_EN
  task automatic test_stats();
    logic [1:0] sy [5] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
    cyc(1, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, sy[i]);
    cyc(0, 1, 0, 2'b00);
    cyc(0, 0, 1, 2'b11);
    cyc(0, 0, 1, 2'b00);
    cyc(0, 1, 0, 2'b00);
    asserts++;
    if (amb_cnt !== 8'd3 || err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL stats: got amb=%0d err=%0d want amb=3 err=1", amb_cnt, err_cnt);
    end
    cyc(0, 0, 1, 2'b10);
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 2'b01);
    asserts++;
    if (amb_cnt !== 8'd255 || err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL stats_sat: got amb=%0d err=%0d want amb=255 err=1", amb_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    mdl_reset();
    test_reset();
    test_sequence1();
    test_sequence2();
    test_error();
    test_hold();
    test_rst_priority();
    test_random();
`ifdef FSMM_DEC_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
